mac_stream_engine: RTL and testbench
====================================

Name: mac_stream_engine

Overview:
- Parametrised successor of the fixed 8-bit / 50-term MAC datapath.
- Streams operand pairs over a valid/ready handshake and accumulates a run-time-selected number of products.
- Supports signed or unsigned operands, per job.
- Offers saturating or wrapping accumulation; overflow is flagged.
- Returns the result over a valid/ready output handshake. Sits between an operand source (FIFO or sequencer) and a result consumer; contains its own control FSM.

Parameters:
- DW, 8: operand width (bits) of a_in and b_in.
- ACCW, 22: accumulator and result width; must be ≥ 2*DW.
- CW, 8: length/counter width; max vector length is 2^CW-1.
- SAT, 1: 1 = saturate on overflow; 0 = wrap modulo 2^ACCW.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  in  1  job start pulse; honoured only in IDLE.
- vec_len  in  CW  number of products in the job; sampled on accepted start.
- signed_mode  in  1  1 = two's-complement operands; sampled on accepted start.
- a_in  in  DW  operand A.
- b_in  in  DW  operand B.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  engine accepts a pair this cycle.
- out_data  out  ACCW  accumulated result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- overflow  out  1  sticky: job overflowed; qualified by out_valid.
- busy  out  1  high in RUN and DONE.
- count  out  CW  pairs accepted in current job.

Behaviour:
- Reset (reset=1 at posedge, overrides all other inputs, any state):
  - state=IDLE; acc, out_data, count, overflow = 0.
  - out_valid, in_ready, busy = 0.
  - Any in-flight job is discarded; no partial result is emitted.
- FSM states: IDLE, RUN, DONE. in_ready and busy are decoded from state (registered state, combinational decode).
- IDLE:
  - in_ready=0.
  - On start=1: acc←0, count←0, overflow←0; latch vec_len→len_q and signed_mode→mode_q.
  - If vec_len==0: out_data←0, out_valid←1, go to DONE. Otherwise go to RUN.
- RUN:
  - in_ready=1.
  - Handshake = in_valid & in_ready. On each handshake: acc←f(acc, a_in*b_in); count←count+1.
  - No handshake: acc and count hold.
  - Handshake when count==len_q-1: out_data←new acc value, out_valid←1, overflow includes this step, go to DONE. Result is valid the cycle after the last accepted pair.
  - start is ignored in RUN.
- DONE:
  - in_ready=0. out_valid=1; out_data and overflow held stable while out_ready=0.
  - On out_valid & out_ready: out_valid←0, go to IDLE. out_data retains its value.
  - start is ignored in DONE, including in the cycle the result is accepted; a new start is honoured from the next IDLE cycle.
- Arithmetic:
  - mode_q=0: product is the unsigned 2*DW-bit product, zero-extended to ACCW.
  - mode_q=1: product is the signed 2*DW-bit product, sign-extended to ACCW.
  - Sum is formed in ACCW+1 bits.
  - Unsigned overflow = carry out of ACCW.
  - Signed overflow = addends share a sign bit and the result sign differs.
- Overflow handling:
  - SAT=1: on overflow, acc clamps to the unsigned max (all ones), or to the signed max/min by the direction of the overflow. Subsequent terms continue from the clamped value.
  - SAT=0: acc wraps.
  - overflow is set on any overflowing step and cleared only by reset or an accepted start.
- count: resets to 0 at start; reads len_q while in DONE; never wraps within a job.

Test Plan:
- Unsigned, SAT=1, vec_len=50, all a=255, b=255, in_valid held high → out_data=3251250, overflow=0, out_valid one cycle after the 50th handshake, count=50.
- Unsigned, vec_len=65, a=b=255 → SAT=1: out_data=4194303, overflow=1. SAT=0: out_data=32321, overflow=1.
- Signed, vec_len=4, a=-3 (0xFD), b=5 → out_data=0x3FFFC4 (-60), overflow=0. Same data with signed_mode=0 → out_data=4*253*5=5060.
- vec_len=0 → out_valid=1 the cycle after start, out_data=0, no in_ready pulse; in_valid bubbles (toggle every other cycle, vec_len=3, products 2, 3, 4) → out_data=9, count advances only on handshakes.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_data/out_valid stable, in_ready=0, start ignored; out_ready=1 → IDLE next cycle.
- Reset asserted for one cycle mid-RUN after 10 pairs → all outputs 0 and state IDLE next cycle; a new start/job of length 2 (3*4, 1*1) → out_data=13.

Source files
------------

// File: rtl/mac_stream_engine.sv
// mac_stream_engine
//   Streaming multiply-accumulate engine. A job is opened with a start pulse
//   in IDLE, which latches the vector length and operand signedness. Operand
//   pairs then arrive over a valid/ready handshake and their products are
//   accumulated. With SAT=1 the sum clamps on overflow; with SAT=0 it wraps.
//   The result is held on a valid/ready output until it is consumed.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        job start pulse (honoured in IDLE only)
//   vec_len      products per job, sampled on accepted start
//   signed_mode  1 = two's-complement operands, sampled on accepted start
//   a_in, b_in   operand pair
//   in_valid     operand pair valid
//   in_ready     engine accepts a pair (RUN)
//   out_data     accumulated result
//   out_valid    result valid (DONE)
//   out_ready    consumer accepts result
//   overflow     sticky overflow for the current job
//   busy         high in RUN and DONE
//   count        pairs accepted in the current job
module mac_stream_engine #(
  parameter int DW   = 8,
  parameter int ACCW = 22,
  parameter int CW   = 8,
  parameter bit SAT  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [CW-1:0]   vec_len,
  input  logic            signed_mode,
  input  logic [DW-1:0]   a_in,
  input  logic [DW-1:0]   b_in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [ACCW-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            overflow,
  output logic            busy,
  output logic [CW-1:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ACCW-1:0] r_acc;
  logic [ACCW-1:0] r_out_data;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_len;
  logic            r_mode;
  logic            r_ovf;

  logic                   w_hs;
  logic                   w_last;
  logic                   w_start_ok;
  logic [2*DW-1:0]        w_prod_u;
  logic signed [2*DW-1:0] w_prod_s;
  logic [ACCW-1:0]        w_prod_ext;
  logic [ACCW:0]          w_sum;
  logic                   w_ovf_u;
  logic                   w_ovf_s;
  logic                   w_ovf;
  logic [ACCW-1:0]        w_clamp;
  logic [ACCW-1:0]        w_acc_nxt;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (vec_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_hs && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_hs       = in_valid && (r_state == S_RUN);
  assign w_last     = (r_count == r_len - CW'(1));
  assign w_start_ok = start && (r_state == S_IDLE);

  // ---------------------------------------------------------------------------
  // Arithmetic
  // ---------------------------------------------------------------------------
  // Both products are formed at full 2*DW width so neither relies on
  // context-determined expression sizing.
  assign w_prod_u = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, b_in};
  assign w_prod_s = $signed({{DW{a_in[DW-1]}}, a_in}) * $signed({{DW{b_in[DW-1]}}, b_in});

  // The size cast on the signed product sign-extends to ACCW.
  assign w_prod_ext = r_mode ? ACCW'(w_prod_s) : ACCW'(w_prod_u);

  assign w_sum   = {1'b0, r_acc} + {1'b0, w_prod_ext};
  assign w_ovf_u = w_sum[ACCW];
  assign w_ovf_s = (r_acc[ACCW-1] == w_prod_ext[ACCW-1]) &&
                   (w_sum[ACCW-1] != r_acc[ACCW-1]);
  assign w_ovf   = r_mode ? w_ovf_s : w_ovf_u;

  // The direction of a signed overflow follows the common sign of the addends.
  always_comb begin
    w_clamp = '1;
    if (r_mode) begin
      w_clamp = r_acc[ACCW-1] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
    end
  end

  assign w_acc_nxt = (SAT && w_ovf) ? w_clamp : w_sum[ACCW-1:0];

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_out_data <= '0;
      r_count    <= '0;
      r_len      <= '0;
      r_mode     <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_start_ok) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_len   <= vec_len;
      r_mode  <= signed_mode;
      if (vec_len == '0) begin
        r_out_data <= '0;
      end
    end else if (w_hs) begin
      r_acc   <= w_acc_nxt;
      r_count <= r_count + CW'(1);
      r_ovf   <= r_ovf | w_ovf;
      if (w_last) begin
        r_out_data <= w_acc_nxt;
      end
    end
  end

  assign out_data = r_out_data;
  assign overflow = r_ovf;
  assign count    = r_count;

endmodule

// File: tb/tb_mac_stream_engine.sv
// tb_mac_stream_engine
//   Directed bench for mac_stream_engine. Two instances share all inputs:
//   u_sat (SAT=1) and u_wrap (SAT=0). Inputs change 1 time unit after the
//   rising edge; outputs are sampled at the same point.
module tb_mac_stream_engine;

  localparam int DW   = 8;
  localparam int ACCW = 22;
  localparam int CW   = 8;

  logic            clk;
  logic            reset;
  logic            start;
  logic [CW-1:0]   vec_len;
  logic            signed_mode;
  logic [DW-1:0]   a_in;
  logic [DW-1:0]   b_in;
  logic            in_valid;
  logic            out_ready;

  logic            s_in_ready, w_in_ready;
  logic [ACCW-1:0] s_out_data, w_out_data;
  logic            s_out_valid, w_out_valid;
  logic            s_overflow, w_overflow;
  logic            s_busy, w_busy;
  logic [CW-1:0]   s_count, w_count;

  int unsigned n_checks;
  int unsigned n_errors;

  mac_stream_engine #(.DW(DW), .ACCW(ACCW), .CW(CW), .SAT(1'b1)) u_sat (
    .clk(clk), .reset(reset), .start(start), .vec_len(vec_len),
    .signed_mode(signed_mode), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
    .in_ready(s_in_ready), .out_data(s_out_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .overflow(s_overflow), .busy(s_busy), .count(s_count)
  );

  mac_stream_engine #(.DW(DW), .ACCW(ACCW), .CW(CW), .SAT(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .vec_len(vec_len),
    .signed_mode(signed_mode), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
    .in_ready(w_in_ready), .out_data(w_out_data), .out_valid(w_out_valid),
    .out_ready(out_ready), .overflow(w_overflow), .busy(w_busy), .count(w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CW-1:0] len, input logic mode);
    start       = 1'b1;
    vec_len     = len;
    signed_mode = mode;
    tick();
    start = 1'b0;
  endtask

  // Holds in_valid high with a constant pair until n handshakes complete.
  task automatic feed(input int unsigned n, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int unsigned acc_n;
    int unsigned cyc;
    acc_n    = 0;
    cyc      = 0;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    while (acc_n < n && cyc < 1000) begin
      if (s_in_ready) acc_n++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("feed_accepted", acc_n, n);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("accept_valid_low", {31'b0, s_out_valid}, 0);
    chk("accept_busy_low", {31'b0, s_busy}, 0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    start       = 1'b0;
    vec_len     = '0;
    signed_mode = 1'b0;
    a_in        = '0;
    b_in        = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    tick();
    tick();
    chk("rst_out_data", 32'(s_out_data), 0);
    chk("rst_out_valid", {31'b0, s_out_valid}, 0);
    chk("rst_in_ready", {31'b0, s_in_ready}, 0);
    chk("rst_busy", {31'b0, s_busy}, 0);
    chk("rst_count", 32'(s_count), 0);
    chk("rst_overflow", {31'b0, s_overflow}, 0);
    reset = 1'b0;
    tick();

    // 50 x 255*255 unsigned: 3251250, fits in 22 bits
    do_start(8'd50, 1'b0);
    chk("u50_in_ready", {31'b0, s_in_ready}, 1);
    chk("u50_busy", {31'b0, s_busy}, 1);
    chk("u50_count0", 32'(s_count), 0);
    feed(50, 8'd255, 8'd255);
    chk("u50_out_valid", {31'b0, s_out_valid}, 1);
    chk("u50_sat_data", 32'(s_out_data), 32'd3251250);
    chk("u50_wrap_data", 32'(w_out_data), 32'd3251250);
    chk("u50_overflow", {31'b0, s_overflow}, 0);
    chk("u50_count", 32'(s_count), 50);
    chk("u50_in_ready_done", {31'b0, s_in_ready}, 0);
    accept();

    // 65 x 65025 = 4226625 overflows 2^22: clamp vs wrap
    do_start(8'd65, 1'b0);
    feed(65, 8'd255, 8'd255);
    chk("u65_sat_data", 32'(s_out_data), 32'd4194303);
    chk("u65_sat_ovf", {31'b0, s_overflow}, 1);
    chk("u65_wrap_data", 32'(w_out_data), 32'd32321);
    chk("u65_wrap_ovf", {31'b0, w_overflow}, 1);
    accept();

    // signed 4 x (-3*5) = -60
    do_start(8'd4, 1'b1);
    feed(4, 8'hFD, 8'd5);
    chk("s4_data", 32'(s_out_data), 32'h003F_FFC4);
    chk("s4_wrap_data", 32'(w_out_data), 32'h003F_FFC4);
    chk("s4_ovf", {31'b0, s_overflow}, 0);
    accept();

    // same operands unsigned: 4 x 253*5
    do_start(8'd4, 1'b0);
    feed(4, 8'hFD, 8'd5);
    chk("u4_data", 32'(s_out_data), 32'd5060);
    accept();

    // zero-length job goes straight to DONE
    do_start(8'd0, 1'b0);
    chk("z_out_valid", {31'b0, s_out_valid}, 1);
    chk("z_out_data", 32'(s_out_data), 0);
    chk("z_in_ready", {31'b0, s_in_ready}, 0);
    chk("z_count", 32'(s_count), 0);
    accept();

    // bubbles on in_valid: 1*2 + 1*3 + 2*2 = 9
    do_start(8'd3, 1'b0);
    in_valid = 1'b1; a_in = 8'd1; b_in = 8'd2;
    tick();
    in_valid = 1'b0;
    chk("bub_count1", 32'(s_count), 1);
    tick();
    chk("bub_count1_hold", 32'(s_count), 1);
    in_valid = 1'b1; a_in = 8'd1; b_in = 8'd3;
    tick();
    in_valid = 1'b0;
    chk("bub_count2", 32'(s_count), 2);
    tick();
    chk("bub_count2_hold", 32'(s_count), 2);
    in_valid = 1'b1; a_in = 8'd2; b_in = 8'd2;
    tick();
    in_valid = 1'b0;
    chk("bub_out_valid", {31'b0, s_out_valid}, 1);
    chk("bub_data", 32'(s_out_data), 9);
    chk("bub_count_done", 32'(s_count), 3);

    // backpressure in DONE with start held high
    start   = 1'b1;
    vec_len = 8'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", {31'b0, s_out_valid}, 1);
      chk("bp_out_data", 32'(s_out_data), 9);
      chk("bp_in_ready", {31'b0, s_in_ready}, 0);
      chk("bp_count", 32'(s_count), 3);
    end
    // start is still high in the accept cycle and must be ignored
    accept();
    start = 1'b0;
    tick();
    chk("bp_idle_stays", {31'b0, s_busy}, 0);
    chk("bp_data_kept", 32'(s_out_data), 9);

    // reset mid-run after 10 pairs
    do_start(8'd20, 1'b0);
    feed(10, 8'd3, 8'd3);
    chk("mid_count10", 32'(s_count), 10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_out_data", 32'(s_out_data), 0);
    chk("mid_rst_out_valid", {31'b0, s_out_valid}, 0);
    chk("mid_rst_in_ready", {31'b0, s_in_ready}, 0);
    chk("mid_rst_busy", {31'b0, s_busy}, 0);
    chk("mid_rst_count", 32'(s_count), 0);
    chk("mid_rst_overflow", {31'b0, s_overflow}, 0);

    // fresh job: 3*4 + 1*1 = 13
    do_start(8'd2, 1'b0);
    feed(1, 8'd3, 8'd4);
    chk("post_count1", 32'(s_count), 1);
    feed(1, 8'd1, 8'd1);
    chk("post_out_valid", {31'b0, s_out_valid}, 1);
    chk("post_data", 32'(s_out_data), 13);
    chk("post_wrap_data", 32'(w_out_data), 13);
    accept();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
